// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring shift-subtract divider: one quotient bit per cycle, WIDTH+1 cycle latency.
// Optional two's-complement mode is compiled in with the SIGNED_DIV_EN macro.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  // The MSB of the partial remainder is always zero after a (restored) step, so only the low
  // WIDTH bits are held; the trial subtraction below is still WIDTH+1 bits wide.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  assign ready  = (state_q != ST_RUN);
  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign accept = start && ready;

`ifdef SIGNED_DIV_EN
  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr_q};
    rem_step = shifted[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
    end
    quo_step  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    // Sign fix-up folded into the DONE-entry edge; MIN/-1 wraps back to MIN naturally.
    quo_final = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
    rem_final = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= a_mag;
      dvsr_q    <= b_mag;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      if (divisor == '0) begin
        state_q     <= ST_DONE;
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        state_q     <= ST_RUN;
        div_by_zero <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q   <= ST_DONE;
            quotient  <= quo_final;
            remainder <= rem_final;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: vector table plus scoreboard, and
// hand-written back-to-back, ignored-start and reset-abort sequences.
module tb_seq_restoring_divider;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          signed_op = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          ready;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sop;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  localparam int NVEC = 12;
  vec_t  tbl[NVEC];
  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  logic [W-1:0] last_q = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call at a negedge with ready=1; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sop,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    exp_t e;
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    signed_op = sop;
    e.q = q;
    e.r = r;
    e.dz = dz;
    sb.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input bit chk_busy);
    int   n = 0;
    int   bc = 0;
    exp_t e;
    while (done !== 1'b1 && n < 200) begin
      bc += int'(busy);
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    if (done !== 1'b1) return;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: done with no pending operation");
      return;
    end
    e = sb.pop_front();
    chk("latency_edges", 32'(cyc - acc_cyc), e.dz ? 32'd0 : 32'(W));
    if (chk_busy) chk("busy_cycles", 32'(bc), e.dz ? 32'd0 : 32'(W));
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
    last_q = e.q;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    logic [W-1:0] prev_q;

    tbl[0]  = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
    tbl[1]  = '{32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b1};
    tbl[2]  = '{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0};
    tbl[3]  = '{32'd1000000, 32'd1000, 1'b0, 32'd1000, 32'd0, 1'b0};
    tbl[4]  = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0};
`ifdef SIGNED_DIV_EN
    tbl[5]  = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    tbl[6]  = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0};
    tbl[7]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0};
`else
    tbl[5]  = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0};
    tbl[6]  = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'd0, 32'd7, 1'b0};
    tbl[7]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 1'b0};
`endif
    tbl[8]  = '{32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
    tbl[9]  = '{32'hDEADBEEF, 32'h10, 1'b0, 32'h0DEADBEE, 32'hF, 1'b0};
    tbl[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0};
    tbl[11] = '{32'd7, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd7, 1'b0};

    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].sop, tbl[i].q, tbl[i].r, tbl[i].dz);
      wait_done(1'b1);
      @(negedge clk);
      chk("done_single_pulse", 32'(done), 32'd0);
      chk("quotient_held", quotient, tbl[i].q);
    end

    // Back-to-back: second start issued in the done cycle.
    issue(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0);
    wait_done(1'b1);
    issue(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
    chk("b2b_done_pulse", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(1'b1);
    @(negedge clk);

    // Start pulsed during RUN must be ignored; outputs stay at the previous result.
    prev_q = last_q;
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    repeat (9) @(negedge clk);
    chk("quotient_stable_in_run", quotient, prev_q);
    start    = 1'b1;
    dividend = 32'h55;
    divisor  = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0);
    @(negedge clk);

    // Reset mid-RUN aborts the operation.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      dcount += int'(done);
    end
    chk("no_done_after_abort", 32'(dcount), 32'd0);
    chk("ready_after_abort", 32'(ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
